// File: rtl/mini_riscv_pkg.sv
// Shared MiniRiscV types: instruction layout, opcodes and the fetch-queue entry.
package mini_riscv_pkg;

    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned FIELD_W   = 4;
    localparam int unsigned IMEM_WORDS = 16;
    localparam int unsigned PC_W      = $clog2(IMEM_WORDS);

    typedef logic [FIELD_W-1:0] opcode_t;

    localparam opcode_t OP_ADD   = 4'b0000;
    localparam opcode_t OP_SUB   = 4'b0001;
    localparam opcode_t OP_MUL   = 4'b0100;
    localparam opcode_t OP_LOAD  = 4'b1000;
    localparam opcode_t OP_STORE = 4'b1001;
    localparam opcode_t OP_NOP   = 4'b1111;

    typedef struct packed {
        opcode_t            opcode;
        logic [FIELD_W-1:0] rd;
        logic [FIELD_W-1:0] rs1;
        logic [FIELD_W-1:0] rs2;
    } instr_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        instr_t          instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; head is read straight from storage.
module fetch_fifo
    import mini_riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop = pop & (count != '0);
    assign head   = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetch with credit-based request issue, redirect/flush and a decode-side queue.
module instr_fetch_queue
    import mini_riscv_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH = 16,
    parameter int unsigned MEM_DEPTH   = 16,
    parameter int unsigned QUEUE_DEPTH = 4,
    localparam int unsigned PC_WIDTH   = $clog2(MEM_DEPTH),
    localparam int unsigned OCC_W      = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req_valid,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [OCC_W-1:0]       occupancy
);

    logic [PC_WIDTH-1:0] fetch_pc_q;
    logic [PC_WIDTH-1:0] resp_pc_q;
    logic                inflight_q;
    logic                pop;
    logic                push;
    logic [OCC_W:0]      pending;
    logic                credit_ok;
    fetch_entry_t        push_data;
    fetch_entry_t        head;
    logic [OCC_W-1:0]    count;

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;

    // A response is only valid if its request was not killed by a redirect arriving with it.
    assign push = inflight_q & ~redirect_valid;

    // Slots already claimed (queued + in flight) minus the one leaving this cycle.
    assign pending   = {1'b0, count} + (OCC_W + 1)'(inflight_q) - (OCC_W + 1)'(pop);
    assign credit_ok = (pending < (OCC_W + 1)'(QUEUE_DEPTH));

    assign imem_req_valid = ~reset & ~redirect_valid & credit_ok;
    assign imem_addr      = fetch_pc_q;

    assign push_data.pc    = resp_pc_q;
    assign push_data.instr = instr_t'(imem_rdata);

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= '0;
            resp_pc_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= imem_req_valid;
            if (imem_req_valid) begin
                resp_pc_q <= fetch_pc_q;
            end
            if (redirect_valid) begin
                fetch_pc_q <= redirect_pc;
            end else if (imem_req_valid) begin
                fetch_pc_q <= fetch_pc_q + PC_WIDTH'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign out_instr = INSTR_WIDTH'(head.instr);
    assign out_pc    = head.pc;
    assign occupancy = count;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: queue-level reference model plus directed and random scenarios.
module tb_instr_fetch_queue;
    import mini_riscv_pkg::*;

    localparam int QD = 4;
    localparam int MD = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [3:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [3:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [3:0]  out_pc;
    logic [2:0]  occupancy;

    logic [15:0] mem [MD];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of buffered PCs, one outstanding request, next fetch PC.
    int mq[$];
    bit m_inf;
    int m_inf_pc;
    int m_fpc;
    bit m_known;
    int delivered[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_req_valid) imem_rdata <= mem[imem_addr];
    end

    instr_fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .occupancy      (occupancy)
    );

    task automatic do_cycle(input bit r, input bit rv, input int rp, input bit rdy);
        int occ;
        bit exp_v;
        bit pop;
        bit exp_req;
        @(negedge clk);
        reset = r; redirect_valid = rv; redirect_pc = 4'(rp); out_ready = rdy;
        #1;
        occ     = mq.size();
        exp_v   = (occ != 0);
        pop     = exp_v && rdy;
        exp_req = !r && !rv && ((occ + int'(m_inf) - int'(pop)) < QD);
        if (r) begin
            n_tests++;
            if (imem_req_valid !== 1'b0) begin
                n_fail++; $display("FAIL req_in_reset: got %b expected 0", imem_req_valid);
            end
        end else if (m_known) begin
            n_tests++;
            if (out_valid !== exp_v) begin
                n_fail++; $display("FAIL out_valid @%0t: got %b expected %b", $time, out_valid, exp_v);
            end
            n_tests++;
            if (occupancy !== 3'(occ)) begin
                n_fail++; $display("FAIL occupancy @%0t: got %0d expected %0d", $time, occupancy, occ);
            end
            n_tests++;
            if (imem_req_valid !== exp_req) begin
                n_fail++; $display("FAIL imem_req_valid @%0t: got %b expected %b", $time, imem_req_valid, exp_req);
            end
            if (exp_req) begin
                n_tests++;
                if (imem_addr !== 4'(m_fpc)) begin
                    n_fail++; $display("FAIL imem_addr @%0t: got %0d expected %0d", $time, imem_addr, m_fpc);
                end
            end
            if (exp_v) begin
                n_tests++;
                if (out_pc !== 4'(mq[0]) || out_instr !== mem[mq[0]]) begin
                    n_fail++;
                    $display("FAIL head @%0t: got pc=%0d instr=%h expected pc=%0d instr=%h",
                             $time, out_pc, out_instr, mq[0], mem[mq[0]]);
                end
            end
        end
        if (!r && out_valid && rdy) delivered.push_back(int'(out_pc));
        if (r) begin
            mq.delete(); m_inf = 0; m_fpc = 0; m_known = 1;
        end else begin
            if (pop) void'(mq.pop_front());
            if (rv) mq.delete();
            else if (m_inf) mq.push_back(m_inf_pc);
            m_inf    = exp_req;
            m_inf_pc = m_fpc;
            if (rv) m_fpc = rp % MD;
            else if (exp_req) m_fpc = (m_fpc + 1) % MD;
        end
    endtask

    task automatic apply_reset();
        do_cycle(1, 0, 0, 0);
        delivered.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        apply_reset();
        do_cycle(0, 0, 0, 0);
        n_tests++;
        if (out_valid !== 1'b0 || occupancy !== 3'd0 || out_pc !== 4'd0 || out_instr !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b occ=%0d pc=%0d instr=%h expected 0/0/0/0",
                     out_valid, occupancy, out_pc, out_instr);
        end
        n_tests++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 4'd0) begin
            n_fail++; $display("FAIL first_req: got v=%b addr=%0d expected 1/0", imem_req_valid, imem_addr);
        end
    endtask

    task automatic test_sequential();
        apply_reset();
        for (int c = 0; c < 20; c++) begin
            do_cycle(0, 0, 0, 1);
            if (c < 2) begin
                n_tests++;
                if (out_valid !== 1'b0) begin
                    n_fail++; $display("FAIL seq_early_valid c%0d: got %b expected 0", c, out_valid);
                end
            end else if (c == 2) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_pc !== 4'd0) begin
                    n_fail++; $display("FAIL seq_first c2: got v=%b pc=%0d expected 1/0", out_valid, out_pc);
                end
            end
        end
        n_tests++;
        if (delivered.size() != 18) begin
            n_fail++; $display("FAIL seq_count: got %0d expected 18", delivered.size());
        end else begin
            for (int i = 0; i < 18; i++) begin
                n_tests++;
                if (delivered[i] != i % MD) begin
                    n_fail++; $display("FAIL seq_pc[%0d]: got %0d expected %0d", i, delivered[i], i % MD);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int nreq = 0;
        logic [3:0] hold_pc;
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            do_cycle(0, 0, 0, 0);
            if (imem_req_valid) begin
                n_tests++;
                if (imem_addr !== 4'(nreq)) begin
                    n_fail++; $display("FAIL bp_addr: got %0d expected %0d", imem_addr, nreq);
                end
                nreq++;
            end
        end
        n_tests++;
        if (nreq != 4 || occupancy !== 3'd4) begin
            n_fail++; $display("FAIL bp_saturate: got reqs=%0d occ=%0d expected 4/4", nreq, occupancy);
        end
        hold_pc = out_pc;
        for (int c = 0; c < 3; c++) begin
            do_cycle(0, 0, 0, 0);
            n_tests++;
            if (out_pc !== hold_pc || out_pc !== 4'd0) begin
                n_fail++; $display("FAIL bp_hold: got pc=%0d expected 0", out_pc);
            end
        end
        for (int c = 0; c < 12; c++) do_cycle(0, 0, 0, 1);
        n_tests++;
        if (delivered.size() != 12) begin
            n_fail++; $display("FAIL bp_drain_count: got %0d expected 12", delivered.size());
        end
        foreach (delivered[i]) begin
            n_tests++;
            if (delivered[i] != i) begin
                n_fail++; $display("FAIL bp_order[%0d]: got %0d expected %0d", i, delivered[i], i);
            end
        end
    endtask

    task automatic test_redirect();
        int exp_list[8] = '{0, 1, 2, 3, 9, 10, 11, 12};
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            do_cycle(0, c == 5, 9, 1);
            if (c == 6) begin
                n_tests++;
                if (occupancy !== 3'd0 || imem_req_valid !== 1'b1 || imem_addr !== 4'd9) begin
                    n_fail++;
                    $display("FAIL redir_c6: got occ=%0d req=%b addr=%0d expected 0/1/9",
                             occupancy, imem_req_valid, imem_addr);
                end
            end
            if (c == 8) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_pc !== 4'd9) begin
                    n_fail++; $display("FAIL redir_c8: got v=%b pc=%0d expected 1/9", out_valid, out_pc);
                end
            end
        end
        n_tests++;
        if (delivered.size() != 8) begin
            n_fail++; $display("FAIL redir_count: got %0d expected 8", delivered.size());
        end else begin
            foreach (exp_list[i]) begin
                n_tests++;
                if (delivered[i] != exp_list[i]) begin
                    n_fail++; $display("FAIL redir_seq[%0d]: got %0d expected %0d", i, delivered[i], exp_list[i]);
                end
            end
        end
    endtask

    task automatic test_redirect_accept();
        int exp_list[5] = '{0, 1, 2, 3, 4};
        apply_reset();
        for (int c = 0; c < 9; c++) begin
            do_cycle(0, c == 3, 2, 1);
            if (c == 3) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_pc !== 4'd1) begin
                    n_fail++; $display("FAIL racc_head: got v=%b pc=%0d expected 1/1", out_valid, out_pc);
                end
            end
        end
        n_tests++;
        if (delivered.size() != 5) begin
            n_fail++; $display("FAIL racc_count: got %0d expected 5", delivered.size());
        end else begin
            foreach (exp_list[i]) begin
                n_tests++;
                if (delivered[i] != exp_list[i]) begin
                    n_fail++; $display("FAIL racc_seq[%0d]: got %0d expected %0d", i, delivered[i], exp_list[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int c = 0; c < 5; c++) do_cycle(0, 0, 0, 0);
        n_tests++;
        if (occupancy !== 3'd3) begin
            n_fail++; $display("FAIL rmid_pre: got occ=%0d expected 3", occupancy);
        end
        apply_reset();
        do_cycle(0, 0, 0, 1);
        n_tests++;
        if (out_valid !== 1'b0 || occupancy !== 3'd0 || out_pc !== 4'd0 || imem_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL rmid_post: got v=%b occ=%0d pc=%0d addr=%0d expected 0/0/0/0",
                     out_valid, occupancy, out_pc, imem_addr);
        end
        do_cycle(0, 0, 0, 1);
        do_cycle(0, 0, 0, 1);
        n_tests++;
        if (out_valid !== 1'b1 || out_pc !== 4'd0) begin
            n_fail++; $display("FAIL rmid_restart: got v=%b pc=%0d expected 1/0", out_valid, out_pc);
        end
    endtask

    task automatic test_random();
        bit rdy;
        bit rv;
        int rp;
        apply_reset();
        for (int c = 0; c < 200; c++) begin
            rdy = bit'($urandom_range(0, 1));
            rv  = ($urandom_range(0, 31) == 0);
            rp  = int'($urandom_range(0, MD - 1));
            do_cycle(0, rv, rp, rdy);
            n_tests++;
            if (occupancy > 3'd4) begin
                n_fail++; $display("FAIL rand_occ_bound: got %0d expected <=4", occupancy);
            end
        end
    endtask

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        m_inf = 0; m_inf_pc = 0; m_fpc = 0; m_known = 0;
        for (int i = 0; i < MD; i++) begin
            mem[i] = {OP_ADD, 4'(i), 4'(i), 4'(i)};
        end
        mem[15] = {OP_NOP, 4'd15, 4'd0, 4'd1};
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_redirect_accept();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
